// File: rtl/jsilicon_alu_pkg.sv
// rtl/jsilicon_alu_pkg.sv - shared op codes and FSM states for the JSilicon sequential ALU
package jsilicon_alu_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_MUL  = 2'b10,
      ALU_RSVD = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      MUL_BUSY = 2'b01,
      DONE     = 2'b10
   } alu_state_e;

endpackage

// File: rtl/jsilicon_mul_iter.sv
// rtl/jsilicon_mul_iter.sv - iterative shift-add unsigned multiplier, one multiplier bit per cycle
module jsilicon_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic                busy_q;
   logic [CW-1:0]       cnt_q;
   logic [2*WIDTH-1:0]  acc_q, acc_d;
   logic [2*WIDTH-1:0]  mcand_q;
   logic [WIDTH-1:0]    mplier_q;

   assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
   // done and product describe the iteration being retired on the coming edge
   assign done    = busy_q && (cnt_q == LAST);
   assign product = acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (start) begin
         busy_q   <= 1'b1;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, a};
         mplier_q <= b;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (cnt_q == LAST) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/jsilicon_alu_seq.sv
// rtl/jsilicon_alu_seq.sv - handshaked ADD/SUB/MUL unit; JSILICON_ALU_SAT_EN enables ADD/SUB saturation
module jsilicon_alu_seq
   import jsilicon_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OP_W-1:0]      op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 carry,
   output logic                 overflow,
   output logic                 zero
);

   alu_state_e          state_q, state_d;
   logic [2*WIDTH-1:0]  result_q, result_d;
   logic                carry_q, carry_d;
   logic                overflow_q, overflow_d;
   logic                zero_q, zero_d;
   logic                load;

   logic [WIDTH:0]      sum, diff;
   logic [WIDTH-1:0]    add_lo, sub_lo;
   logic                add_ovf, sub_ovf;
   logic                mul_start, mul_done;
   logic [2*WIDTH-1:0]  mul_product;

   assign sum     = {1'b0, a} + {1'b0, b};
   assign diff    = {1'b0, a} - {1'b0, b};
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      add_lo = sum[WIDTH-1:0];
      sub_lo = diff[WIDTH-1:0];
`ifdef JSILICON_ALU_SAT_EN
      if (sum[WIDTH])  add_lo = '1;
      if (diff[WIDTH]) sub_lo = '0;
`endif
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign mul_start = in_valid && in_ready && (alu_op_e'(op) == ALU_MUL);

   jsilicon_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      load       = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               case (alu_op_e'(op))
                  ALU_ADD: begin
                     state_d    = DONE;
                     load       = 1'b1;
                     result_d   = {{WIDTH{1'b0}}, add_lo};
                     carry_d    = sum[WIDTH];
                     overflow_d = add_ovf;
                  end
                  ALU_SUB: begin
                     state_d    = DONE;
                     load       = 1'b1;
                     result_d   = {{WIDTH{1'b0}}, sub_lo};
                     carry_d    = diff[WIDTH];
                     overflow_d = sub_ovf;
                  end
                  ALU_MUL: state_d = MUL_BUSY;
                  ALU_RSVD: begin
                     state_d    = DONE;
                     load       = 1'b1;
                     result_d   = '0;
                     carry_d    = 1'b0;
                     overflow_d = 1'b1;
                  end
               endcase
            end
         end
         MUL_BUSY: begin
            if (mul_done) begin
               state_d    = DONE;
               load       = 1'b1;
               result_d   = mul_product;
               carry_d    = 1'b0;
               overflow_d = |mul_product[2*WIDTH-1:WIDTH];
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (load) zero_d = ~|result_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         result_q   <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
      end
   end

   assign result   = result_q;
   assign carry    = carry_q;
   assign overflow = overflow_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_jsilicon_alu_seq.sv
// tb/tb_jsilicon_alu_seq.sv - directed self-checking bench for jsilicon_alu_seq at WIDTH=8
module tb_jsilicon_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'b00;
   logic [7:0]  a = 8'h00;
   logic [7:0]  b = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] result;
   logic        carry, overflow, zero;

   int total = 0;
   int bad = 0;
   int lat;
   bit rdy_seen;

   always #5 clk = ~clk;

   jsilicon_alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives one request from a point #1 after an edge; returns once out_valid is seen
   // (lat = edges from the accept edge inclusive), leaving the handshake edge unconsumed.
   task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         output int latency, output bit ready_seen);
      in_valid = 1'b1; op = o; a = x; b = y;
      check("accept_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; op = 2'b11; a = 8'hA5; b = 8'h5A;
      latency = 1;
      ready_seen = 1'b0;
      while (!out_valid && latency < 40) begin
         ready_seen |= in_ready;
         @(posedge clk); #1;
         latency++;
      end
      if (!out_valid) check("out_valid_timeout", 0, 1);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("hs_out_valid_low", out_valid, 0);
      check("hs_in_ready_high", in_ready, 1);
   endtask

   initial begin
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", {carry, overflow, zero}, 3'b000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      run_op(2'b00, 8'd200, 8'd100, lat, rdy_seen);
      check("add1_lat", lat, 1);
`ifdef JSILICON_ALU_SAT_EN
      check("add1_result", result, 16'h00FF);
`else
      check("add1_result", result, 16'h002C);
`endif
      check("add1_cvz", {carry, overflow, zero}, 3'b100);
      handshake();

      run_op(2'b01, 8'd5, 8'd10, lat, rdy_seen);
      check("sub1_lat", lat, 1);
`ifdef JSILICON_ALU_SAT_EN
      check("sub1_result", result, 16'h0000);
      check("sub1_cvz", {carry, overflow, zero}, 3'b101);
`else
      check("sub1_result", result, 16'h00FB);
      check("sub1_cvz", {carry, overflow, zero}, 3'b100);
`endif
      handshake();

      run_op(2'b10, 8'd255, 8'd255, lat, rdy_seen);
      check("mul1_lat", lat, 9);
      check("mul1_ready_low", rdy_seen, 0);
      check("mul1_result", result, 16'hFE01);
      check("mul1_cvz", {carry, overflow, zero}, 3'b010);
      handshake();

      run_op(2'b10, 8'd13, 8'd11, lat, rdy_seen);
      check("mul2_result", result, 16'd143);
      check("mul2_cvz", {carry, overflow, zero}, 3'b000);
      handshake();

      run_op(2'b10, 8'd0, 8'd77, lat, rdy_seen);
      check("mul0_result", result, 16'h0000);
      check("mul0_cvz", {carry, overflow, zero}, 3'b001);
      handshake();

      run_op(2'b00, 8'd127, 8'd1, lat, rdy_seen);
      check("add2_result", result, 16'h0080);
      check("add2_cvz", {carry, overflow, zero}, 3'b010);
      handshake();

      run_op(2'b01, 8'h80, 8'h01, lat, rdy_seen);
      check("sub2_result", result, 16'h007F);
      check("sub2_cvz", {carry, overflow, zero}, 3'b010);
      handshake();

      run_op(2'b11, 8'd9, 8'd9, lat, rdy_seen);
      check("rsvd_lat", lat, 1);
      check("rsvd_result", result, 16'h0000);
      check("rsvd_cvz", {carry, overflow, zero}, 3'b011);
      handshake();

      // backpressure: stall 5 cycles while offering a competing request
      out_ready = 1'b0;
      run_op(2'b00, 8'd3, 8'd4, lat, rdy_seen);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; op = 2'b00; a = 8'd100; b = 8'd100;
         check("stall_result", result, 16'h0007);
         check("stall_valid", out_valid, 1);
         check("stall_ready", in_ready, 0);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      handshake();
      check("stall_after_result", result, 16'h0007);

      // reset during the 4th multiply iteration
      in_valid = 1'b1; op = 2'b10; a = 8'd255; b = 8'd255;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_result", result, 0);
      check("midrst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(2'b00, 8'd1, 8'd1, lat, rdy_seen);
      check("postrst_lat", lat, 1);
      check("postrst_result", result, 16'h0002);
      handshake();

      run_op(2'b10, 8'd3, 8'd5, lat, rdy_seen);
      check("postrst_mul_lat", lat, 9);
      check("postrst_mul_result", result, 16'd15);
      handshake();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
